// File: rtl/secded_scrub_ctrl.sv
// SECDED scrub sequencer: sweeps the codeword RAM through the
// external detector/corrector and writes single-error fixes back.
module secded_scrub_ctrl #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [7:0]        mem_rdata,
  output logic              mem_wr_en,
  output logic [7:0]        mem_wdata,
  output logic [7:0]        chk_word,
  input  logic [2:0]        dp_sindrome,
  input  logic              dp_error_simple,
  input  logic              dp_error_doble,
  input  logic [7:0]        dp_corregido,
  output logic [CNT_W-1:0]  single_cnt,
  output logic [CNT_W-1:0]  double_cnt,
  output logic              dbl_valid,
  output logic [ADDR_W-1:0] dbl_addr
);

  typedef enum logic [2:0] {
    IDLE, READ, WAIT, CHECK, WRITE, DONE
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] dbl_addr_q;
  logic              busy_q;
  logic              done_q;
  logic              rd_q;
  logic              wr_q;
  logic              dbl_valid_q;
  logic [7:0]        chk_q;
  logic [7:0]        wdata_q;
  logic [CNT_W-1:0]  sgl_q;
  logic [CNT_W-1:0]  dbl_q;
  logic [CNT_W-1:0]  sgl_d;
  logic [CNT_W-1:0]  dbl_d;
  logic              last;
  logic              fix;
  logic              unused_syn;

  // syndrome is informational only; the flags drive control
  assign unused_syn = ^dp_sindrome;

  // saturating increments and end-of-sweep detect
  assign sgl_d = (&sgl_q) ? sgl_q : sgl_q + 1'b1;
  assign dbl_d = (&dbl_q) ? dbl_q : dbl_q + 1'b1;
  assign last  = (addr_q == ADDR_W'(DEPTH - 1));
  assign fix   = dp_error_simple & ~dp_error_doble;

  // sweep sequencer with registered strobes and status
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      dbl_addr_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      dbl_valid_q <= 1'b0;
      chk_q       <= '0;
      wdata_q     <= '0;
      sgl_q       <= '0;
      dbl_q       <= '0;
    end else begin
      done_q <= 1'b0;
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q     <= READ;
            busy_q      <= 1'b1;
            rd_q        <= 1'b1;
            addr_q      <= '0;
            sgl_q       <= '0;
            dbl_q       <= '0;
            dbl_valid_q <= 1'b0;
            dbl_addr_q  <= '0;
          end
        end
        READ: state_q <= WAIT;
        WAIT: begin
          chk_q   <= mem_rdata;
          state_q <= CHECK;
        end
        CHECK: begin
          if (fix) begin
            wdata_q <= dp_corregido;
            sgl_q   <= sgl_d;
            wr_q    <= 1'b1;
            state_q <= WRITE;
          end else begin
            if (dp_error_doble) begin
              dbl_q <= dbl_d;
              if (!dbl_valid_q) begin
                dbl_valid_q <= 1'b1;
                dbl_addr_q  <= addr_q;
              end
            end
            if (last) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              addr_q  <= addr_q + 1'b1;
              rd_q    <= 1'b1;
              state_q <= READ;
            end
          end
        end
        WRITE: begin
          if (last) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            addr_q  <= addr_q + 1'b1;
            rd_q    <= 1'b1;
            state_q <= READ;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign mem_addr   = addr_q;
  assign mem_rd_en  = rd_q;
  assign mem_wr_en  = wr_q;
  assign mem_wdata  = wdata_q;
  assign chk_word   = chk_q;
  assign single_cnt = sgl_q;
  assign double_cnt = dbl_q;
  assign dbl_valid  = dbl_valid_q;
  assign dbl_addr   = dbl_addr_q;

endmodule

// File: tb/tb_secded_scrub_ctrl.sv
// Bench for secded_scrub_ctrl: two instances (CNT_W=8 and CNT_W=2)
// run identical sweeps against RAM and datapath models.
module tb_secded_scrub_ctrl;
  localparam int D = 16;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic load;
  always #5 clk = ~clk;

  logic       busy[2], done[2], rd[2], wr[2], dv[2];
  logic [3:0] addr[2], daddr[2];
  logic [7:0] rdata[2], wdata[2], cw[2], corr[2];
  logic       es[2], ed[2];
  logic [2:0] syn[2];
  logic [7:0] sc0, dc0;
  logic [1:0] sc1, dc1;

  logic [7:0]   ram[2][D];
  logic [7:0]   init_w[D];
  logic [7:0]   mask[D];
  logic [7:0]   exp_ram[D];
  logic [D-1:0] sflag, dflag;

  int nerr = 0;
  int ncheck = 0;

  secded_scrub_ctrl #(.DEPTH(16), .ADDR_W(4), .CNT_W(8)) u0 (
    .clk(clk), .rst(rst), .start(start), .busy(busy[0]), .done(done[0]),
    .mem_addr(addr[0]), .mem_rd_en(rd[0]), .mem_rdata(rdata[0]),
    .mem_wr_en(wr[0]), .mem_wdata(wdata[0]), .chk_word(cw[0]),
    .dp_sindrome(syn[0]), .dp_error_simple(es[0]), .dp_error_doble(ed[0]),
    .dp_corregido(corr[0]), .single_cnt(sc0), .double_cnt(dc0),
    .dbl_valid(dv[0]), .dbl_addr(daddr[0]));

  secded_scrub_ctrl #(.DEPTH(16), .ADDR_W(4), .CNT_W(2)) u1 (
    .clk(clk), .rst(rst), .start(start), .busy(busy[1]), .done(done[1]),
    .mem_addr(addr[1]), .mem_rd_en(rd[1]), .mem_rdata(rdata[1]),
    .mem_wr_en(wr[1]), .mem_wdata(wdata[1]), .chk_word(cw[1]),
    .dp_sindrome(syn[1]), .dp_error_simple(es[1]), .dp_error_doble(ed[1]),
    .dp_corregido(corr[1]), .single_cnt(sc1), .double_cnt(dc1),
    .dbl_valid(dv[1]), .dbl_addr(daddr[1]));

  // datapath model: flags per address, correction flips the mask bits
  for (genvar g = 0; g < 2; g++) begin : g_dp
    assign es[g]   = sflag[addr[g]];
    assign ed[g]   = dflag[addr[g]];
    assign corr[g] = cw[g] ^ mask[addr[g]];
    assign syn[g]  = cw[g][2:0];
  end

  // synchronous RAM models with backdoor load
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (load) begin
        for (int a = 0; a < D; a++) ram[i][a] <= init_w[a];
      end else begin
        if (rd[i]) rdata[i] <= ram[i][addr[i]];
        if (wr[i]) ram[i][addr[i]] <= wdata[i];
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    ncheck++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int sat3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  task automatic load_ram();
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic setup_flip(input logic [D-1:0] s, input logic [D-1:0] d);
    sflag = s;
    dflag = d;
    for (int a = 0; a < D; a++) begin
      mask[a]   = 8'h01;
      init_w[a] = s[a] ? 8'h3D : 8'h3C;
    end
    load_ram();
  endtask

  // reference: walk addresses in order applying the scrub rules
  task automatic model(input int cmax, output int xs, output int xd,
                       output int xv, output int xa, output int xc,
                       output int xw);
    xs = 0; xd = 0; xv = 0; xa = 0; xc = 1; xw = 0;
    for (int a = 0; a < D; a++) begin
      exp_ram[a] = init_w[a];
      if (dflag[a]) begin
        if (xd < cmax) xd++;
        if (xv == 0) begin xv = 1; xa = a; end
        xc += 3;
      end else if (sflag[a]) begin
        if (xs < cmax) xs++;
        xw++;
        exp_ram[a] = init_w[a] ^ mask[a];
        xc += 4;
      end else begin
        xc += 3;
      end
    end
  endtask

  task automatic run_sweep(input int restart_at, output int cyc,
                           output int nd, output int nw0, output int nw1,
                           output int clash, output int first_sc);
    cyc = 0; nd = 0; nw0 = 0; nw1 = 0; clash = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_rise", busy[0], 1);
    chk("rd_first", rd[0], 1);
    first_sc = sc0;
    for (int k = 1; k <= 300; k++) begin
      if (wr[0]) nw0++;
      if (wr[1]) nw1++;
      if ((rd[0] && wr[0]) || (rd[1] && wr[1])) clash++;
      if (done[0]) begin nd++; cyc = k; end
      if (!busy[0]) break;
      start = (k == restart_at);
      @(negedge clk);
    end
    start = 1'b0;
    chk("sweep_end", busy[0], 0);
  endtask

  task automatic verify(input int xs, input int xd, input int xv,
                        input int xa, input int xc, input int xw,
                        input int cyc, input int nd, input int nw0,
                        input int nw1, input int clash);
    int bad;
    chk("cycles", cyc, xc);
    chk("done_pulses", nd, 1);
    chk("writes0", nw0, xw);
    chk("writes1", nw1, xw);
    chk("rd_wr_clash", clash, 0);
    chk("single0", sc0, xs);
    chk("double0", dc0, xd);
    chk("single1", sc1, sat3(xs));
    chk("double1", dc1, sat3(xd));
    chk("dbl_valid0", dv[0], xv);
    chk("dbl_valid1", dv[1], xv);
    chk("dbl_addr0", daddr[0], xa);
    chk("dbl_addr1", daddr[1], xa);
    bad = 0;
    for (int a = 0; a < D; a++) begin
      if (ram[0][a] !== exp_ram[a]) bad++;
      if (ram[1][a] !== exp_ram[a]) bad++;
    end
    chk("ram_readback", bad, 0);
  endtask

  typedef struct {
    logic [D-1:0] s;
    logic [D-1:0] d;
    int xs, xd, xv, xa, xc, xw;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int cyc, nd, nw0, nw1, clash, fsc;
    int xs, xd, xv, xa, xc, xw;
    int found;

    tbl[0] = '{16'h0000, 16'h0000, 0, 0, 0, 0, 49, 0};
    tbl[1] = '{16'h0020, 16'h0000, 1, 0, 0, 0, 50, 1};
    tbl[2] = '{16'h0200, 16'h0204, 0, 2, 1, 2, 49, 0};
    tbl[3] = '{16'h8001, 16'h8000, 1, 1, 1, 15, 50, 1};
    tbl[4] = '{16'h0155, 16'h0000, 5, 0, 0, 0, 54, 5};

    rst = 1'b1; start = 1'b0; load = 1'b0;
    sflag = '0; dflag = '0;
    for (int a = 0; a < D; a++) begin
      mask[a] = 8'h01; init_w[a] = 8'h3C;
    end
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rst_busy", busy[0], 0);
    chk("rst_done", done[0], 0);
    chk("rst_rd", rd[0], 0);
    chk("rst_wr", wr[0], 0);
    chk("rst_addr", addr[0], 0);
    chk("rst_cnt", sc0 + dc0, 0);
    chk("rst_dv", dv[0], 0);
    chk("rst_cw", cw[0], 0);
    chk("rst_wdata", wdata[0], 0);
    @(negedge clk);
    chk("start_with_rst_ignored", busy[0], 0);

    for (int i = 0; i < 5; i++) begin
      setup_flip(tbl[i].s, tbl[i].d);
      model(255, xs, xd, xv, xa, xc, xw);
      run_sweep(0, cyc, nd, nw0, nw1, clash, fsc);
      verify(tbl[i].xs, tbl[i].xd, tbl[i].xv, tbl[i].xa, tbl[i].xc,
             tbl[i].xw, cyc, nd, nw0, nw1, clash);
    end
    chk("addr5_fixed_value", ram[0][5], 8'h3C);

    setup_flip(16'h0020, 16'h0000);
    run_sweep(10, cyc, nd, nw0, nw1, clash, fsc);
    chk("restart_done_pulses", nd, 1);
    chk("restart_cycles", cyc, 50);
    repeat (2) @(negedge clk);
    chk("hold_after_done", sc0, 1);
    setup_flip(16'h0020, 16'h0000);
    run_sweep(0, cyc, nd, nw0, nw1, clash, fsc);
    chk("clear_on_start", fsc, 0);
    chk("recount", sc0, 1);

    setup_flip(16'h0080, 16'h0000);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int k = 0; k < 100; k++) begin
      if (wr[0] && addr[0] == 4'd7) begin found = 1; break; end
      @(negedge clk);
    end
    chk("write7_reached", found, 1);
    chk("pre_rst_cnt", sc0, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", busy[0], 0);
    chk("midrst_wr", wr[0], 0);
    chk("midrst_cnt0", sc0, 0);
    chk("midrst_cnt1", sc1, 0);
    chk("midrst_addr", addr[0], 0);
    chk("midrst_cw", cw[0], 0);
    chk("midrst_wdata", wdata[0], 0);
    found = 0;
    for (int k = 0; k < 6; k++) begin
      if (done[0] || busy[0]) found++;
      @(negedge clk);
    end
    chk("midrst_quiet", found, 0);

    for (int r = 0; r < 25; r++) begin
      int ys, yd, yv, ya, yc, yw;
      sflag = 16'($urandom);
      dflag = 16'($urandom & $urandom);
      for (int a = 0; a < D; a++) begin
        init_w[a] = 8'($urandom);
        mask[a]   = 8'(1 << $urandom_range(0, 7));
      end
      load_ram();
      model(3, ys, yd, yv, ya, yc, yw);
      model(255, xs, xd, xv, xa, xc, xw);
      run_sweep(0, cyc, nd, nw0, nw1, clash, fsc);
      verify(xs, xd, xv, xa, xc, xw, cyc, nd, nw0, nw1, clash);
      chk("rand_sat_single1", sc1, ys);
      chk("rand_sat_double1", dc1, yd);
    end

    $display("Result: errors=%0d of %0d checks", nerr, ncheck);
    $finish;
  end

endmodule
